// File: rtl/fft_peak_detect_pkg.sv
// rtl/fft_peak_detect_pkg.sv - shared fixed-point, bin and result types for the fft spectral path
package fft_peak_detect_pkg;

    localparam int FFT_N = 3;
    localparam int FPT_W = 16;
    localparam int NBINS = 1 << FFT_N;
    localparam int POW_W = 2 * FPT_W;
    localparam int ACC_W = POW_W + FFT_N;

    typedef logic signed [FPT_W-1:0] fpt;
    typedef fpt [1:0] t_bin;
    typedef logic [FFT_N-1:0] bin_idx_t;
    typedef logic [FFT_N:0] bin_cnt_t;

    typedef enum logic {IDLE, COLLECT} state_t;

    typedef struct packed {
        logic     valid;
        logic     first;
        logic     last;
        bin_idx_t idx;
    } bin_tag_t;

endpackage

// File: rtl/fft_peak_detect_cplx_pow.sv
// rtl/fft_peak_detect_cplx_pow.sv - two-stage registered |X|^2 with tag passthrough
module cplx_pow
    import fft_peak_detect_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  t_bin             in_bin,
    input  bin_tag_t         in_tag,
    output logic [POW_W-1:0] pow,
    output bin_tag_t         pow_tag
);

    logic [POW_W-1:0] re_ext, im_ext, re_prod, im_prod;
    logic [POW_W-1:0] re_sq, im_sq;
    bin_tag_t         p1_tag;

    // Low 2W bits of the sign-extended product are the exact square (at most 2^30).
    assign re_ext  = {{FPT_W{in_bin[1][FPT_W-1]}}, in_bin[1]};
    assign im_ext  = {{FPT_W{in_bin[0][FPT_W-1]}}, in_bin[0]};
    assign re_prod = re_ext * re_ext;
    assign im_prod = im_ext * im_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            re_sq   <= '0;
            im_sq   <= '0;
            p1_tag  <= '0;
            pow     <= '0;
            pow_tag <= '0;
        end else begin
            re_sq   <= re_prod;
            im_sq   <= im_prod;
            p1_tag  <= in_tag;
            pow     <= re_sq + im_sq;
            pow_tag <= p1_tag;
            // An abandoned frame's entry in P1 must not reach the accumulator as valid.
            if (flush) begin
                pow_tag.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-frame peak bin, peak power and frame energy with held result
module fft_peak_detect
    import fft_peak_detect_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FPT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_start,
    input  logic [2*W-1:0]   in_bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     peak_idx,
    output logic [2*W-1:0]   peak_pow,
    output logic [2*W+N-1:0] frame_pow,
    output logic [7:0]       overrun
);

    state_t           state, state_nxt;
    bin_cnt_t         cnt;
    bin_tag_t         in_tag, pow_tag;
    logic             abort;
    t_bin             bin_in;
    logic [POW_W-1:0] pow;
    logic [POW_W-1:0] pk_pow;
    bin_idx_t         pk_idx;
    logic [ACC_W-1:0] acc;
    logic             done;

    assign bin_in = in_bin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_start) state_nxt = COLLECT;
            COLLECT: if (!in_start && cnt == bin_cnt_t'(NBINS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_tag = '0;
        abort  = 1'b0;
        if (in_start) begin
            in_tag.valid = 1'b1;
            in_tag.first = 1'b1;
            abort        = (state == COLLECT);
        end else if (state == COLLECT) begin
            in_tag.valid = 1'b1;
            in_tag.idx   = cnt[FFT_N-1:0];
            in_tag.last  = (cnt == bin_cnt_t'(NBINS - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (in_start) begin
            cnt <= bin_cnt_t'(1);
        end else if (state == COLLECT) begin
            cnt <= cnt + bin_cnt_t'(1);
        end
    end

    cplx_pow u_pow (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .in_bin  (bin_in),
        .in_tag  (in_tag),
        .pow     (pow),
        .pow_tag (pow_tag)
    );

    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pk_pow <= '0;
            pk_idx <= '0;
            acc    <= '0;
            done   <= 1'b0;
        end else begin
            done <= pow_tag.valid && pow_tag.last;
            if (pow_tag.valid) begin
                if (pow_tag.first) begin
                    pk_pow <= pow;
                    pk_idx <= pow_tag.idx;
                    acc    <= ACC_W'(pow);
                end else begin
                    if (pow > pk_pow) begin
                        pk_pow <= pow;
                        pk_idx <= pow_tag.idx;
                    end
                    acc <= acc + ACC_W'(pow);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            peak_idx  <= '0;
            peak_pow  <= '0;
            frame_pow <= '0;
            overrun   <= '0;
        end else if (done) begin
            if (res_valid && !res_ready) begin
                overrun <= (overrun == 8'hff) ? overrun : overrun + 8'd1;
            end else begin
                res_valid <= 1'b1;
                peak_idx  <= pk_idx;
                peak_pow  <= pk_pow;
                frame_pow <= acc;
            end
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - scoreboard bench for fft_peak_detect
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_start = 1'b0;
    logic [31:0] in_bin = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [2:0]  peak_idx;
    logic [31:0] peak_pow;
    logic [34:0] frame_pow;
    logic [7:0]  overrun;

    typedef struct {
        longint idx;
        longint pk;
        longint fp;
    } exp_t;

    exp_t               exp_q[$];
    int                 n_checks = 0;
    int                 n_pass = 0;
    longint             exp_overrun = 0;
    logic signed [15:0] fre[8];
    logic signed [15:0] fim[8];

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk       (clk),
        .reset     (reset),
        .in_start  (in_start),
        .in_bin    (in_bin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .peak_idx  (peak_idx),
        .peak_pow  (peak_pow),
        .frame_pow (frame_pow),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_all(input logic signed [15:0] re, input logic signed [15:0] im);
        for (int i = 0; i < 8; i++) begin
            fre[i] = re;
            fim[i] = im;
        end
    endtask

    task automatic send_frame(input int nbins, input bit push);
        longint p, pk, idx, fp;
        exp_t   e;
        for (int i = 0; i < nbins; i++) begin
            @(negedge clk);
            in_start = (i == 0);
            in_bin   = {fre[i], fim[i]};
        end
        if (push) begin
            pk = -1; idx = 0; fp = 0;
            for (int i = 0; i < 8; i++) begin
                p = longint'(fre[i]) * longint'(fre[i]) + longint'(fim[i]) * longint'(fim[i]);
                fp += p;
                if (p > pk) begin
                    pk  = p;
                    idx = i;
                end
            end
            e.idx = idx; e.pk = pk; e.fp = fp;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_start = 1'b0;
            in_bin   = '0;
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Results are compared at the handshake, sampled between negedge and the next posedge.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("peak_idx", peak_idx, e.idx);
                check("peak_pow", peak_pow, e.pk);
                check("frame_pow", frame_pow, e.fp);
                check("overrun", overrun, exp_overrun);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", res_valid, 0);
        check("rst_idx", peak_idx, 0);
        check("rst_peak", peak_pow, 0);
        check("rst_frame", frame_pow, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        set_all(1, 1);
        fre[3] = 1000; fim[3] = -2000;
        send_frame(8, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_start = 1'b0;
            in_bin   = '0;
            check($sformatf("latency_%0d", k), res_valid, (k == 4) ? 1 : 0);
        end
        drain("drain_single");

        set_all(10, -5);
        fre[2] = -300; fim[2] = 400;
        fre[5] = -300; fim[5] = 400;
        send_frame(8, 1);
        idle(1);
        drain("drain_tie");

        set_all(16'sh8000, 16'sh8000);
        send_frame(8, 1);
        idle(1);
        drain("drain_extreme");

        res_ready = 1'b0;
        set_all(5, 5);
        fre[6] = 700;
        send_frame(8, 1);
        fre[1] = 900;
        send_frame(8, 0);
        fim[4] = -1500;
        send_frame(8, 0);
        idle(8);
        exp_overrun = 2;
        check("hold_valid", res_valid, 1);
        check("hold_overrun", overrun, 2);
        check("hold_idx", peak_idx, exp_q[0].idx);
        check("hold_peak", peak_pow, exp_q[0].pk);
        check("hold_frame", frame_pow, exp_q[0].fp);
        res_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", res_valid, 0);
        set_all(-3, 7);
        fre[7] = -1234;
        send_frame(8, 1);
        idle(1);
        drain("drain_after_overrun");

        set_all(2, 2);
        fre[1] = 20000;
        send_frame(4, 0);
        set_all(3, -4);
        fim[5] = 100;
        send_frame(8, 1);
        idle(1);
        drain("drain_abort");
        idle(6);
        check("abort_overrun", overrun, 2);
        check("abort_no_result", res_valid, 0);

        set_all(4, 4);
        send_frame(5, 0);
        @(negedge clk);
        in_bin = {fre[5], fim[5]};
        #2;
        reset = 1'b0;
        #1;
        exp_overrun = 0;
        check("midrst_valid", res_valid, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_peak", peak_pow, 0);
        check("midrst_frame", frame_pow, 0);
        check("midrst_idx", peak_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        set_all(7, -1);
        fim[2] = 50;
        send_frame(8, 1);
        idle(1);
        drain("drain_after_midrst");

        res_ready = 1'b0;
        set_all(9, 9);
        fre[0] = 60;
        send_frame(8, 1);
        for (int k = 0; k < 20 && !res_valid; k++) idle(1);
        check("held_before_rst", res_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("heldrst_valid", res_valid, 0);
        check("heldrst_peak", peak_pow, 0);
        check("heldrst_frame", frame_pow, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        res_ready = 1'b1;
        idle(2);
        set_all(-100, 250);
        fre[6] = -30000;
        send_frame(8, 1);
        idle(1);
        drain("drain_after_heldrst");

        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
